mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter DW, default 8, meaning the data width in bits.
REQ-002 The module SHALL have parameter AW, default 5, meaning the address width (depth 2**AW = 32 words).
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0  input  1  port 0 (processor) access request, held until granted.
REQ-006 we0  input  1  port 0 write enable (1 = write, 0 = read), qualified by req0.
REQ-007 addr0  input  AW  port 0 word address.
REQ-008 wdata0  input  DW  port 0 write data.
REQ-009 gnt0  output  1  port 0 grant, combinational, same cycle as req0.
REQ-010 rvalid0  output  1  port 0 read-data-valid, one-cycle pulse.
REQ-011 rdata0  output  DW  port 0 read data, registered.
REQ-012 req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1 SHALL mirror REQ-005..REQ-011 for port 1 (host/loader).
REQ-013 busy  output  1  high in any cycle where req0 or req1 is high.

Function
REQ-014 The block SHALL contain one DW x 2**AW register-array memory shared by both ports; at most one access per clock.
REQ-015 Handshake: an access is accepted at the rising edge where reqN=1 and gntN=1; the requester holds we/addr/wdata stable from req assertion until that edge.
REQ-016 Only one requester: it is granted in the same cycle (gnt = req), no bubble.
REQ-017 Both requesting: the port NOT recorded in last_grant is granted; the other sees gnt=0 and waits.
REQ-018 last_grant SHALL update to the granted port index at every accepted access and hold when no access occurs.
REQ-019 gnt0 and gnt1 SHALL never be high in the same cycle, and gntN SHALL never be high while reqN=0.
REQ-020 Accepted write: mem[addr] <= wdata at the accepting edge; rvalid and rdata of that port unchanged by the write.
REQ-021 Accepted read: at the accepting edge rdataN <= mem[addr] and rvalidN <= 1; rvalidN SHALL be 0 in the following cycle unless another read from that port is accepted.
REQ-022 rdataN SHALL hold its last value when no read from port N is accepted.
REQ-023 Read latency SHALL be exactly 1 cycle: data valid in the cycle after acceptance, coincident with rvalidN.
REQ-024 A write accepted at edge k followed by a read of the same address (either port) accepted at edge k+1 SHALL return the newly written data.
REQ-025 Back-to-back accepted accesses from the same port in consecutive cycles SHALL be supported when the other port is idle (full throughput).
REQ-026 Worst-case wait for a continuously requesting port SHALL be 1 cycle (strict alternation under constant contention).
REQ-027 Addresses SHALL be taken modulo 2**AW; no out-of-range condition exists.

Reset
REQ-028 While rst=1: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0, no memory write occurs.
REQ-029 On rst assertion (asynchronous): all memory words SHALL clear to 0 and last_grant SHALL be set to 1, so port 0 wins the first tie.
REQ-030 A read accepted at the edge before reset SHALL NOT produce an rvalid pulse after reset is released.
REQ-031 First edge after rst deasserts SHALL arbitrate normally.

Verification
REQ-032 After reset, port 0 reads addr 5 -> gnt0=1 same cycle, next cycle rvalid0=1, rdata0=8'h00.
REQ-033 Port 1 writes 8'hA5 to addr 3, next cycle port 0 reads addr 3 -> rvalid0=1 with rdata0=8'hA5 one cycle later.
REQ-034 Both ports request continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; gnt0 and gnt1 never both high.
REQ-035 Port 0 issues 4 consecutive reads of addr 0..3 (prefilled 8'h10..8'h13), port 1 idle -> rvalid0 high 4 consecutive cycles with data 8'h10,8'h11,8'h12,8'h13.
REQ-036 Port 1 read accepted, rst asserted mid-cycle before next edge -> rvalid1=0, rdata1=0 immediately; memory reads 0 after release.
REQ-037 Write 8'hFF to addr 31 then read addr 31 -> 8'hFF; read addr 0 unaffected (8'h00).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a shared register-array memory.
// Fair tie-break: on contention the port that was not granted last wins.
module mem_arbiter #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  // port 0 (processor)
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // port 1 (host/loader)
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic          last_grant;
  logic          acc;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Same-cycle grant; on a tie the port not recorded in last_grant wins
  assign gnt0 = ~rst & req0 & (~req1 | last_grant);
  assign gnt1 = ~rst & req1 & (~req0 | ~last_grant);
  assign busy = ~rst & (req0 | req1);

  // Mux the granted port onto the single memory access path
  assign acc       = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  // Memory array, read data registers and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      last_grant <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (acc) begin
        last_grant <= gnt1;
      end
      if (acc && sel_we) begin
        mem[sel_addr] <= sel_wdata;
      end
      if (gnt0 && !we0) begin
        rdata0 <= mem[addr0];
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem[addr1];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .gnt0   (gnt0),
    .rvalid0(rvalid0),
    .rdata0 (rdata0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .gnt1   (gnt1),
    .rvalid1(rvalid1),
    .rdata1 (rdata1),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // reset state, even with both ports requesting
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rst_gnt0",    32'(gnt0),    32'h0);
    chk("rst_gnt1",    32'(gnt1),    32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1), 32'h0);
    chk("rst_rdata0",  32'(rdata0),  32'h0);
    chk("rst_rdata1",  32'(rdata1),  32'h0);
    idle();
    rst = 1'b0;

    // port 0 reads addr 5 after reset
    req0 = 1'b1; addr0 = 5'd5;
    #1;
    chk("r5_gnt0", 32'(gnt0), 32'h1);
    chk("r5_gnt1", 32'(gnt1), 32'h0);
    chk("r5_busy", 32'(busy), 32'h1);
    tick();
    idle();
    chk("r5_rvalid0", 32'(rvalid0), 32'h1);
    chk("r5_rdata0",  32'(rdata0),  32'h00);
    tick();
    chk("r5_rvalid0_pulse", 32'(rvalid0), 32'h0);
    chk("idle_busy",        32'(busy),    32'h0);

    // port 1 writes A5 to addr 3, port 0 reads it at the next edge
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd3; wdata1 = 8'hA5;
    #1;
    chk("w3_gnt1", 32'(gnt1), 32'h1);
    tick();
    idle();
    chk("w3_rvalid1", 32'(rvalid1), 32'h0);
    req0 = 1'b1; addr0 = 5'd3;
    #1;
    chk("r3_gnt0", 32'(gnt0), 32'h1);
    tick();
    idle();
    chk("r3_rvalid0", 32'(rvalid0), 32'h1);
    chk("r3_rdata0",  32'(rdata0),  32'hA5);

    // top address write/read, addr 0 unaffected, back to back on port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd31; wdata0 = 8'hFF;
    tick();
    chk("w31_rvalid0", 32'(rvalid0), 32'h0);
    chk("w31_rdata0",  32'(rdata0),  32'hA5);
    we0 = 1'b0; addr0 = 5'd31;
    tick();
    chk("r31_rvalid0", 32'(rvalid0), 32'h1);
    chk("r31_rdata0",  32'(rdata0),  32'hFF);
    addr0 = 5'd0;
    tick();
    idle();
    chk("r0_rvalid0", 32'(rvalid0), 32'h1);
    chk("r0_rdata0",  32'(rdata0),  32'h00);
    tick();
    chk("r0_rvalid0_pulse", 32'(rvalid0), 32'h0);

    // prefill addr 0..3 from port 1 back to back
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; we1 = 1'b1; addr1 = AW'(i); wdata1 = DW'(8'h10 + i);
      tick();
    end
    idle();
    // four consecutive reads on port 0
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; addr0 = AW'(i);
      #1;
      chk($sformatf("burst_gnt0_%0d", i), 32'(gnt0), 32'h1);
      tick();
      chk($sformatf("burst_rvalid0_%0d", i), 32'(rvalid0), 32'h1);
      chk($sformatf("burst_rdata0_%0d", i),  32'(rdata0),  32'h10 + 32'(i));
    end
    idle();
    tick();
    chk("burst_end_rvalid0", 32'(rvalid0), 32'h0);

    // port 1 read then reset asserted mid-cycle
    req1 = 1'b1; addr1 = 5'd1;
    tick();
    idle();
    chk("pre_rst_rvalid1", 32'(rvalid1), 32'h1);
    chk("pre_rst_rdata1",  32'(rdata1),  32'h11);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid1", 32'(rvalid1), 32'h0);
    chk("mid_rst_rdata1",  32'(rdata1),  32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rvalid1", 32'(rvalid1), 32'h0);

    // constant contention from reset: strict alternation, memory cleared
    req0 = 1'b1; addr0 = 5'd3;
    req1 = 1'b1; addr1 = 5'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt_gnt0_%0d", i), 32'(gnt0), 32'((i % 2) == 0));
      chk($sformatf("alt_gnt1_%0d", i), 32'(gnt1), 32'((i % 2) == 1));
      chk($sformatf("alt_excl_%0d", i), 32'(gnt0 & gnt1), 32'h0);
      tick();
      if ((i % 2) == 0) begin
        chk($sformatf("alt_rvalid0_%0d", i), 32'(rvalid0), 32'h1);
        chk($sformatf("alt_rvalid1_%0d", i), 32'(rvalid1), 32'h0);
        chk($sformatf("alt_rdata0_%0d", i),  32'(rdata0),  32'h0);
      end else begin
        chk($sformatf("alt_rvalid0_%0d", i), 32'(rvalid0), 32'h0);
        chk($sformatf("alt_rvalid1_%0d", i), 32'(rvalid1), 32'h1);
        chk($sformatf("alt_rdata1_%0d", i),  32'(rdata1),  32'h0);
      end
    end
    idle();

    // addr 1 held 8'h11 before reset; it must now read 0
    req1 = 1'b1; addr1 = 5'd1;
    tick();
    idle();
    chk("clr_rdata1", 32'(rdata1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
